// File: rtl/bcd_ascii_pkg.sv
// Shared types and ASCII helpers for the BCD-to-ASCII transmit path.
package bcd_ascii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_EMIT,
        ST_SEP,
        ST_DONE
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_SEP   = 8'd58;
    localparam logic [7:0] ASCII_SLASH = 8'd47;

    // Inverse of the ASCII digit decoder: 0..9 -> '0'..'9', 0xA -> ':', 0xB -> '/'
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        case (nib)
            4'hA:    return ASCII_SEP;
            4'hB:    return ASCII_SLASH;
            default: return ASCII_ZERO + 8'(nib);
        endcase
    endfunction

endpackage

// File: rtl/dabble_conv.sv
// Sequential shift-add-3 binary-to-BCD converter; one bit per cycle while run is high.
module dabble_conv #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  run,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  finished,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] cnt_q;

    // Pre-shift correction so each nibble stays a valid decimal digit after doubling
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            bcd      <= '0;
            cnt_q    <= '0;
            finished <= 1'b0;
        end else if (load) begin
            bin_q    <= bin_i;
            bcd      <= '0;
            cnt_q    <= '0;
            finished <= 1'b0;
        end else if (run && !finished) begin
            bcd      <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_q    <= {bin_q[BIN_W-2:0], 1'b0};
            cnt_q    <= cnt_q + CNT_W'(1);
            finished <= (cnt_q == CNT_W'(BIN_W - 1));
        end
    end

endmodule

// File: rtl/bcd2ascii_tx.sv
// Binary value to ASCII decimal digit stream plus ':' separator over valid/ready.
// Define ZERO_SUPPRESS_EN to skip leading zero digits (units digit always sent).
module bcd2ascii_tx
    import bcd_ascii_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             done
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef ZERO_SUPPRESS_EN
    localparam bit ZS_EN = 1'b1;
`else
    localparam bit ZS_EN = 1'b0;
`endif

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d, pidx_c;
    logic                 busy_d, tx_valid_d, done_d;
    logic [7:0]           tx_data_d;
    logic                 conv_load_c, conv_run_c, conv_fin;
    logic [DIGITS*4-1:0]  bcd;
    logic                 hs_c, present_c, leading_c, skip_c;
    logic [3:0]           digit_c;

    assign hs_c = tx_valid && tx_ready;

    dabble_conv #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .load     (conv_load_c),
        .run      (conv_run_c),
        .bin_i    (bin_i),
        .finished (conv_fin),
        .bcd      (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            busy     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy     <= busy_d;
            tx_valid <= tx_valid_d;
            tx_data  <= tx_data_d;
            done     <= done_d;
        end
    end

    // Next state plus next values of the registered byte interface
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy;
        tx_valid_d  = tx_valid;
        tx_data_d   = tx_data;
        done_d      = 1'b0;
        conv_load_c = 1'b0;
        conv_run_c  = 1'b0;
        present_c   = 1'b0;
        leading_c   = 1'b0;
        pidx_c      = idx_q;
        digit_c     = 4'h0;
        skip_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    conv_load_c = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_CONV;
                end
            end
            ST_CONV: begin
                conv_run_c = 1'b1;
                if (conv_fin) begin
                    state_d   = ST_EMIT;
                    present_c = 1'b1;
                    leading_c = 1'b1;
                    pidx_c    = IDX_W'(DIGITS - 1);
                end
            end
            ST_EMIT: begin
                if (hs_c) begin
                    if (idx_q == '0) begin
                        state_d    = ST_SEP;
                        tx_valid_d = 1'b1;
                        tx_data_d  = ASCII_SEP;
                    end else begin
                        present_c = 1'b1;
                        pidx_c    = idx_q - IDX_W'(1);
                    end
                end else if (!tx_valid) begin
                    // Previous digit was a suppressed leading zero
                    present_c = 1'b1;
                    leading_c = 1'b1;
                    pidx_c    = idx_q - IDX_W'(1);
                end
            end
            ST_SEP: begin
                if (hs_c) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (present_c) begin
            idx_d      = pidx_c;
            digit_c    = bcd[4*int'(pidx_c) +: 4];
            skip_c     = ZS_EN && leading_c && (digit_c == 4'h0) && (pidx_c != '0);
            tx_valid_d = !skip_c;
            tx_data_d  = nibble_to_ascii(digit_c);
        end
    end

endmodule

// File: doc/bcd2ascii_tx.md
# bcd2ascii_tx

Sequential number-to-text transmitter: converts a binary value to BCD digits by shift-add-3 (double dabble) and streams them as ASCII bytes over a valid/ready byte interface, followed by a ':' separator. It is the transmit-side counterpart to the ASCII digit decoder. That decoder maps ASCII '0'..'9' to codes 0..9, ':' to code 0xA and '/' to code 0xB. This block sits between the number-producing logic and the UART/byte TX path.

## Interface
- BIN_W, default 16, binary input width.
- DIGITS, default 5, BCD digits emitted. Must satisfy 10^DIGITS > 2^BIN_W − 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle request; samples bin_i; honoured only in IDLE.
- bin_i  in  BIN_W  unsigned value to transmit.
- busy  out  1  high from the cycle after an accepted start until done.
- tx_data  out  8  ASCII byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready at a rising edge.
- done  out  1  one-cycle pulse after the separator is accepted.

## Operation
- States: IDLE, CONV, EMIT, SEP, DONE.
- IDLE:
  - On start, load bin_i into the shift register and clear the BCD register.
  - Clear the bit counter, then go to CONV.
- CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by one. After BIN_W cycles, go to EMIT with the digit index set to DIGITS−1 (most significant digit).
- EMIT:
  - tx_data = 8'd48 + nibble[index].
  - On handshake, decrement index. After index 0 is accepted, go to SEP.
- SEP: tx_data = 8'd58 (':'). On handshake, go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- Nibble values above 9 cannot occur. The encoder also maps 0xA to 58 and 0xB to 47 for symmetry with the decoder.
- start outside IDLE is ignored. bin_i is not re-sampled.
- tx_data and tx_valid hold stable while tx_valid && !tx_ready. No byte is dropped or duplicated.
- Reset values: busy=0, tx_valid=0, tx_data=8'h00, done=0, state=IDLE, all registers cleared.
- Reset mid-operation aborts immediately. No partial stream resumes afterwards.

## Timing
- start sampled at edge 0. busy=1 from edge 0. CONV occupies edges 1..BIN_W.
- First tx_valid is high after edge BIN_W+1.
- With tx_ready held high, one byte per cycle: DIGITS digits, then the separator.
- done pulses in the cycle after the separator handshake. busy falls with done's falling edge, i.e. busy is low when the state returns to IDLE.
- A new start is accepted the cycle IDLE is re-entered.
- tx_valid is registered. tx_ready has no combinational path to tx_valid.

## Configuration
- ZERO_SUPPRESS_EN defined:
  - In EMIT, leading zero digits are skipped. Each skipped digit costs one cycle with tx_valid=0.
  - The units digit is always emitted, so value 0 emits '0' then ':'.
- ZERO_SUPPRESS_EN undefined: exactly DIGITS digits are always emitted, zero-padded.

## Structure
- Package bcd_ascii_pkg holds:
  - the state enum;
  - ASCII_ZERO=8'd48, ASCII_SEP=8'd58, ASCII_SLASH=8'd47;
  - a nibble-to-ASCII function.
- One sub-module, dabble_conv: the sequential BIN_W-cycle converter with load, run and finished signals and a DIGITS×4 BCD output. The top FSM handles sequencing and the byte interface.

## Test plan
- bin_i=12345, tx_ready=1 → bytes 0x31,0x32,0x33,0x34,0x35,0x3A on consecutive cycles; first valid at edge 17; one done pulse.
- bin_i=42, macro off → 0x30,0x30,0x30,0x34,0x32,0x3A. Macro on → 0x34,0x32,0x3A.
- bin_i=0, macro on → 0x30,0x3A. bin_i=65535 → 0x36,0x35,0x35,0x33,0x35,0x3A.
- Backpressure: tx_ready low for 3 cycles while presenting 0x33 → tx_data holds 0x33 with valid high; the sequence continues unchanged and exactly once.
- start pulsed with bin_i=999 during EMIT of 12345 → ignored; the stream remains 12345; the next start after done transmits 00999.
- rst asserted during EMIT → tx_valid, busy and done go 0 asynchronously. After release, start with 7 → 0x30,0x30,0x30,0x30,0x37,0x3A.
